// File: rtl/ex_mem.sv
// EX/MEM pipeline register for the 5-stage MIPS core.
// Carries GPR/HI-LO write info to MEM and holds the madd/msub intermediate for EX.
module ex_mem #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned STALL_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic                  ex_we,
  input  logic [ADDR_W-1:0]     ex_waddr,
  input  logic [DATA_W-1:0]     ex_result,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [2*DATA_W-1:0]   hilo_tmp_i,
  input  logic [1:0]            cnt_i,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_W-1:0]     mem_result,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [2*DATA_W-1:0]   hilo_tmp_o,
  output logic [1:0]            cnt_o
);

  localparam int unsigned EX_BIT  = 3;
  localparam int unsigned MEM_BIT = 4;

  logic ex_stall;
  logic mem_stall;
  logic unused_stall;

  assign ex_stall     = stall[EX_BIT];
  assign mem_stall    = stall[MEM_BIT];
  assign unused_stall = ^{stall[STALL_W-1:MEM_BIT+1], stall[EX_BIT-1:0]};

  // Flush beats any stall; EX-only stall emits a bubble and parks the madd intermediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_result <= '0;
      mem_whilo  <= 1'b0;
      mem_hi     <= '0;
      mem_lo     <= '0;
      hilo_tmp_o <= '0;
      cnt_o      <= 2'b00;
    end else if (flush) begin
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_result <= '0;
      mem_whilo  <= 1'b0;
      mem_hi     <= '0;
      mem_lo     <= '0;
      hilo_tmp_o <= '0;
      cnt_o      <= 2'b00;
    end else if (ex_stall && !mem_stall) begin
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_result <= '0;
      mem_whilo  <= 1'b0;
      mem_hi     <= '0;
      mem_lo     <= '0;
      hilo_tmp_o <= hilo_tmp_i;
      cnt_o      <= cnt_i;
    end else if (!ex_stall) begin
      mem_we     <= ex_we;
      mem_waddr  <= ex_waddr;
      mem_result <= ex_result;
      mem_whilo  <= ex_whilo;
      mem_hi     <= ex_hi;
      mem_lo     <= ex_lo;
      hilo_tmp_o <= '0;
      cnt_o      <= 2'b00;
    end
  end

endmodule
